sipo_deserializer: RTL and testbench
====================================

// Module: sipo_deserializer
// PURPOSE
//  Serial-in/parallel-out receiver downstream of the PISO shift register stage.
//  Accepts an LSB-first bit stream qualified by ser_valid. A start marker on the
//  first bit delimits each frame. Reassembles WIDTH-bit words and presents them
//  on a one-entry valid/ready output buffer. Flags words lost to back-pressure.
// PARAMETERS
//  WIDTH   4   word width in bits (>=2); bit 0 is received first
// PORTS
//  clk         in   1      rising-edge clock
//  reset       in   1      asynchronous, active-low reset
//  ser_in      in   1      serial data bit
//  ser_valid   in   1      ser_in sampled on clk edge when 1
//  start       in   1      qualifies ser_in as bit 0 of a new frame (with ser_valid)
//  data_out    out  WIDTH  reassembled word, stable while data_valid=1
//  data_valid  out  1      output buffer holds a word
//  data_ready  in   1      consumer accepts data_out when data_valid&data_ready
//  overrun     out  1      sticky: a completed word was dropped
//  clr_err     in   1      synchronous clear of overrun
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, bit count=0, shift reg=0, data_out=0,
//   data_valid=0, overrun=0. Reset mid-frame discards the partial word.
//  States: IDLE, SHIFT.
//   IDLE: ser_valid&start -> capture bit0, cnt=1, go SHIFT.
//    ser_valid without start is ignored.
//   SHIFT: each ser_valid shifts in the next bit: sr <= {ser_in, sr[WIDTH-1:1]};
//    cnt++. The ser_valid that brings cnt to WIDTH completes the word
//    {ser_in, sr[WIDTH-1:1]} and returns to IDLE.
//    ser_valid=0 cycles hold state (gaps allowed, no timeout).
//   start&ser_valid in SHIFT: partial word abandoned (no flag).
//    That bit becomes bit0 of a new frame; cnt=1.
//  Completion (same edge as last bit): word loads data_out, data_valid=1, if the
//   buffer is empty or being popped this cycle (data_valid&data_ready).
//   Otherwise word dropped, data_out unchanged, overrun<=1.
//  Latency: data_valid visible in the cycle after the edge sampling bit WIDTH-1.
//  Pop: data_valid&data_ready with no completing word -> data_valid<=0.
//   data_out keeps its last value.
//  Simultaneous pop+complete: new word loads, data_valid stays 1, no overrun.
//  Back-to-back frames: start may accompany the bit right after a completing bit.
//  WIDTH=1 special case not supported.
//  overrun: set on drop; clr_err clears it.
//   Set wins if a drop and clr_err happen in the same cycle.
//  data_out changes only on load or reset.
//  Counter width is $clog2(WIDTH+1).
// TESTING
//  1 Assert reset mid-run -> data_valid=0, overrun=0, data_out=0; next frame clean.
//  2 Send 4'hB as 1,1,0,1 (start on first), ready=1 -> data_out=4'hB,
//    data_valid=1 for one cycle, after 4th bit.
//  3 ready=0, send 4'h3 then 4'hC -> data_out stays 4'h3, overrun=1.
//    clr_err -> overrun=0.
//  4 Send 2 bits, then start+4 bits of 4'h5 -> only 4'h5 delivered.
//  5 Gapped ser_valid (random idle cycles) for 4'hA -> data_out=4'hA; no early valid.
//  6 Continuous frames 4'h1,4'h2,4'h3 with ready=1 -> three words in order, no overrun.
//    Include a pop coinciding with completion.

Source files
------------

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - LSB-first serial-to-parallel receiver with one-entry valid/ready output buffer
module sipo_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             start,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  input  logic             clr_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] word;
  logic             restart;
  logic             advance;
  logic             complete;
  logic             pop;
  logic             load;
  logic             drop;

  assign word     = {ser_in, sr[WIDTH-1:1]};
  assign restart  = ser_valid & start;
  assign advance  = (state == SHIFT) & ser_valid & ~start;
  assign complete = advance & (cnt == CW'(WIDTH - 1));
  assign pop      = data_valid & data_ready;
  // A word may only land when the buffer is empty or is being drained this same edge.
  assign load     = complete & (~data_valid | data_ready);
  assign drop     = complete & data_valid & ~data_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (restart) state_next = SHIFT;
      end
      SHIFT: begin
        if (restart)       state_next = SHIFT;
        else if (complete) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit 0 enters at the MSB so that WIDTH-1 further shifts walk it down to bit 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (restart) begin
      sr  <= {ser_in, {(WIDTH-1){1'b0}}};
      cnt <= CW'(1);
    end else if (advance) begin
      sr  <= word;
      cnt <= complete ? '0 : cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        data_out   <= word;
        data_valid <= 1'b1;
      end else if (pop) begin
        data_valid <= 1'b0;
      end
      if (drop)         overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - directed self-checking bench for sipo_deserializer
module tb_sipo_deserializer;

  logic       clk;
  logic       reset;
  logic       ser_in;
  logic       ser_valid;
  logic       start;
  logic [3:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       overrun;
  logic       clr_err;

  int total;
  int passed;

  sipo_deserializer #(.WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .ser_in     (ser_in),
    .ser_valid  (ser_valid),
    .start      (start),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .overrun    (overrun),
    .clr_err    (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock with the given serial inputs; inputs return to idle #1 after the edge.
  task automatic cyc(input logic sv, input logic si, input logic st);
    ser_valid = sv;
    ser_in    = si;
    start     = st;
    @(posedge clk);
    #1;
    ser_valid = 1'b0;
    ser_in    = 1'b0;
    start     = 1'b0;
    clr_err   = 1'b0;
  endtask

  initial begin
    logic [3:0] w;
    int gap;
    total      = 0;
    passed     = 0;
    reset      = 1'b0;
    ser_in     = 1'b0;
    ser_valid  = 1'b0;
    start      = 1'b0;
    data_ready = 1'b0;
    clr_err    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(data_valid), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_data", 32'(data_out), 32'h0);
    reset = 1'b1;
    cyc(0, 0, 0);

    // 4'hB = 1,1,0,1 LSB first, ready held high
    data_ready = 1'b1;
    cyc(1, 1, 1);
    chk("b_bit0_valid", 32'(data_valid), 32'h0);
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    chk("b_bit2_valid", 32'(data_valid), 32'h0);
    cyc(1, 1, 0);
    chk("b_valid", 32'(data_valid), 32'h1);
    chk("b_data", 32'(data_out), 32'hB);
    cyc(0, 0, 0);
    chk("b_popped", 32'(data_valid), 32'h0);
    chk("b_data_hold", 32'(data_out), 32'hB);

    // back-pressure: 4'h3 held, 4'hC dropped
    data_ready = 1'b0;
    w = 4'h3;
    for (int i = 0; i < 4; i++) cyc(1, w[i], i == 0);
    chk("bp_first_valid", 32'(data_valid), 32'h1);
    chk("bp_first_data", 32'(data_out), 32'h3);
    w = 4'hC;
    for (int i = 0; i < 4; i++) cyc(1, w[i], i == 0);
    chk("bp_overrun", 32'(overrun), 32'h1);
    chk("bp_data_kept", 32'(data_out), 32'h3);
    chk("bp_valid_kept", 32'(data_valid), 32'h1);
    clr_err = 1'b1;
    cyc(0, 0, 0);
    chk("clr_overrun", 32'(overrun), 32'h0);
    // drop and clr_err on the same edge: set wins
    w = 4'h9;
    for (int i = 0; i < 3; i++) cyc(1, w[i], i == 0);
    clr_err = 1'b1;
    cyc(1, w[3], 0);
    chk("set_wins", 32'(overrun), 32'h1);
    chk("set_wins_data", 32'(data_out), 32'h3);

    // async reset mid-frame with a full buffer and overrun pending
    cyc(1, 1, 1);
    cyc(1, 1, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(data_valid), 32'h0);
    chk("mid_rst_overrun", 32'(overrun), 32'h0);
    chk("mid_rst_data", 32'(data_out), 32'h0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    // bits without start are ignored in IDLE; then a clean 4'h6
    data_ready = 1'b1;
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    w = 4'h6;
    for (int i = 0; i < 4; i++) cyc(1, w[i], i == 0);
    chk("post_rst_valid", 32'(data_valid), 32'h1);
    chk("post_rst_data", 32'(data_out), 32'h6);
    cyc(0, 0, 0);

    // two-bit partial frame abandoned by a new start
    cyc(1, 1, 1);
    cyc(1, 0, 0);
    w = 4'h5;
    cyc(1, w[0], 1);
    cyc(1, w[1], 0);
    chk("restart_no_early", 32'(data_valid), 32'h0);
    cyc(1, w[2], 0);
    chk("restart_no_early2", 32'(data_valid), 32'h0);
    cyc(1, w[3], 0);
    chk("restart_valid", 32'(data_valid), 32'h1);
    chk("restart_data", 32'(data_out), 32'h5);
    cyc(0, 0, 0);
    chk("restart_popped", 32'(data_valid), 32'h0);

    // gapped ser_valid for 4'hA
    w = 4'hA;
    for (int i = 0; i < 4; i++) begin
      cyc(1, w[i], i == 0);
      if (i < 3) begin
        gap = $urandom_range(1, 3);
        for (int g = 0; g < gap; g++) cyc(0, 1, 0);
        chk("gap_no_early", 32'(data_valid), 32'h0);
      end
    end
    chk("gap_valid", 32'(data_valid), 32'h1);
    chk("gap_data", 32'(data_out), 32'hA);

    // continuous frames 1,2,3; frame 2 completes on the same edge word 1 is popped
    w = 4'h1;
    for (int i = 0; i < 4; i++) cyc(1, w[i], i == 0);
    chk("cont1_valid", 32'(data_valid), 32'h1);
    chk("cont1_data", 32'(data_out), 32'h1);
    data_ready = 1'b0;
    w = 4'h2;
    for (int i = 0; i < 3; i++) cyc(1, w[i], i == 0);
    chk("cont1_held", 32'(data_out), 32'h1);
    chk("cont1_held_valid", 32'(data_valid), 32'h1);
    data_ready = 1'b1;
    cyc(1, w[3], 0);
    chk("cont2_valid", 32'(data_valid), 32'h1);
    chk("cont2_data", 32'(data_out), 32'h2);
    chk("cont2_overrun", 32'(overrun), 32'h0);
    w = 4'h3;
    cyc(1, w[0], 1);
    chk("cont3_popped", 32'(data_valid), 32'h0);
    for (int i = 1; i < 4; i++) cyc(1, w[i], 0);
    chk("cont3_valid", 32'(data_valid), 32'h1);
    chk("cont3_data", 32'(data_out), 32'h3);
    chk("cont3_overrun", 32'(overrun), 32'h0);
    cyc(0, 0, 0);
    chk("cont_drained", 32'(data_valid), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
